// File: rtl/alu_bist_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_bist_pkg: shared constants and state type for the ALU BIST path |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package alu_bist_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  localparam logic [ALU_WIDTH-1:0] DEFAULT_POLY = 32'h04C1_1DB7;
  localparam logic [ALU_WIDTH-1:0] DEFAULT_SEED = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bist_state_t;

endpackage
`default_nettype wire

// File: rtl/misr32.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | misr32: combinational next-state function of a shift-left MISR     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module misr32
  import alu_bist_pkg::*;
#(
  parameter int unsigned          WIDTH = ALU_WIDTH,
  parameter logic [WIDTH-1:0]     POLY  = DEFAULT_POLY
) (
  input  logic [WIDTH-1:0] sig,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] next_sig
);

  assign next_sig = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ data;

endmodule
`default_nettype wire

// File: rtl/alu_sig_checker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_sig_checker: compacts ALU results into a MISR, compares golden  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module alu_sig_checker
  import alu_bist_pkg::*;
#(
  parameter int unsigned      WIDTH = ALU_WIDTH,
  parameter int unsigned      CNT_W = 8,
  parameter logic [WIDTH-1:0] POLY  = DEFAULT_POLY,
  parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [WIDTH-1:0] golden_sig,
  input  logic             result_valid,
  input  logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] vec_count
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  bist_state_t      r_state;
  bist_state_t      w_state_nxt;
  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] r_golden;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_num_vec;
  logic             r_pass;
  logic [WIDTH-1:0] w_next_sig;
  logic             w_absorb;
  logic             w_last;
  logic             w_zero_len;

  misr32 #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr (
    .sig      (r_sig),
    .data     (result),
    .next_sig (w_next_sig)
  );

  // RUN always holds num_vec >= 1, so the minus-one never wraps here
  assign w_absorb   = (r_state == ST_RUN) && result_valid;
  assign w_last     = (r_count == (r_num_vec - C_ONE));
  assign w_zero_len = (num_vec == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (start) w_state_nxt = w_zero_len ? ST_DONE : ST_RUN;
        ST_RUN:           if (result_valid && w_last) w_state_nxt = ST_DONE;
        default:          w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Abort leaves signature and count visible for post-mortem inspection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig     <= SEED;
      r_count   <= '0;
      r_num_vec <= '0;
      r_golden  <= '0;
      r_pass    <= 1'b0;
    end else if (abort) begin
      r_pass <= 1'b0;
    end else if ((r_state != ST_RUN) && start) begin
      r_num_vec <= num_vec;
      r_golden  <= golden_sig;
      r_sig     <= SEED;
      r_count   <= '0;
      r_pass    <= w_zero_len && (SEED == golden_sig);
    end else if (w_absorb) begin
      r_sig   <= w_next_sig;
      r_count <= r_count + C_ONE;
      if (w_last) r_pass <= (w_next_sig == r_golden);
    end
  end

  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign pass      = done && r_pass;
  assign signature = r_sig;
  assign vec_count = r_count;

endmodule
`default_nettype wire

// File: doc/alu_sig_checker.md
# alu_sig_checker

Response-side companion to the ALU stimulus path: consumes a stream of ALU results and compacts them into a 32-bit multiple-input signature register (MISR), then compares the final signature against a golden value. It sits at the ALU output in the BIST/bring-up path and turns a run of N vectors into a single pass/fail flag. It never stalls the producer; it samples every cycle that `result_valid` is high while a run is active.

## Interface
- `WIDTH`, 32: result and signature width.
- `CNT_W`, 8: width of the vector counter and `num_vec`.
- `POLY`, 32'h04C11DB7: MISR feedback polynomial.
- `SEED`, 32'h00000000: signature value loaded at run start and at reset.

- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `start` in 1: begin a run; honoured only in IDLE or DONE.
- `abort` in 1: cancel the current run; return to IDLE.
- `num_vec` in CNT_W: number of results in the run; sampled when `start` is accepted.
- `golden_sig` in WIDTH: expected signature; sampled when `start` is accepted.
- `result_valid` in 1: `result` carries a valid ALU output this cycle.
- `result` in WIDTH: ALU output word.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE (level, held until next `start` or `abort`).
- `pass` out 1: final signature equals golden; meaningful only while `done`=1, else 0.
- `signature` out WIDTH: current MISR contents.
- `vec_count` out CNT_W: results absorbed so far in this run.

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- Reset values: `busy`=0, `done`=0, `pass`=0, `signature`=SEED, `vec_count`=0, latched num_vec/golden = 0.
- IDLE/DONE + `start`: latch `num_vec`, `golden_sig`; `signature`<=SEED; `vec_count`<=0; `pass`<=0; go RUN. If latched `num_vec`=0, go directly DONE with `pass`=(SEED==golden_sig).
- RUN + `result_valid`: `signature` <= {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ `result`; `vec_count`++.
- RUN, accepted result is the last (`vec_count`==num_vec-1): same edge sets DONE and `pass`=(next signature==latched golden).
- RUN without `result_valid`: hold everything.
- `result_valid` in IDLE or DONE: ignored; signature and count unchanged.
- `start` in RUN: ignored.
- `abort` (any state): next edge to IDLE, `pass`=0, `done`=0; signature and count hold. `abort` wins over `start` and `result_valid` in the same cycle.
- DONE holds `signature`, `vec_count`, `pass` stable until `start`/`abort`.
- Counter arithmetic unsigned, CNT_W bits; num_vec max 2^CNT_W-1, no wrap within a run.

## Timing
- `start` accepted at edge k -> `busy`=1 after k; first result can be absorbed at edge k+1.
- Each valid result absorbed in one cycle; throughput 1 result/cycle, no back-pressure.
- Last result at edge m -> `done`=1, `busy`=0, `pass` and final `signature` visible after m (zero extra latency).
- `rst_n` low at any time, including mid-run: all outputs return to reset values immediately; no partial run survives.

## Structure
- Shared package `alu_bist_pkg`: state enum (IDLE/RUN/DONE), default POLY and SEED constants, WIDTH constant shared with stimulus generator.
- One sub-module natural: `misr32` (combinational next-signature function of sig, data, POLY); FSM, counter and compare stay in the top.

## Test plan
- Reset then idle: `rst_n` low, `result_valid`=1 with data -> `signature`=0, `done`=0, `busy`=0 throughout.
- Two-vector run: start num_vec=2, golden=32'h04C11DB6; results 32'hFFFFFFFF then 32'hFFFFFFFF -> signature 32'hFFFFFFFF after first, 32'h04C11DB6 after second, `done`=1, `pass`=1 same cycle.
- Mismatch and gaps: same data with `result_valid` gaps of 3 idle cycles, golden=32'h00000000 -> signature still 32'h04C11DB6, `pass`=0, `vec_count`=2.
- Zero-length run: num_vec=0, golden=32'h00000000 -> DONE one cycle after start, `pass`=1, `vec_count`=0.
- Abort/restart: 8-vector run aborted after 3 results (abort and valid same cycle) -> IDLE, `vec_count`=3; new start then completes normally with fresh SEED.
- Async reset mid-run: `rst_n` pulsed low between edges during RUN -> outputs at reset values before next edge; subsequent run unaffected.
